// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, shifted out MSB first.
// Optional even-parity bit per word when SER_PARITY_EN is defined.
module bit_serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic             o_bit_out,
    output logic             o_bit_valid,
    output logic             o_word_done,
    output logic             o_busy
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
`ifdef SER_PARITY_EN
        S_SHIFT = 2'd1,
        S_PARITY = 2'd2
`else
        S_SHIFT = 2'd1
`endif
    } state_t;

    state_t           r_state, w_state_n;
    logic [WIDTH-1:0] r_shreg, w_shreg_n;
    logic [CW-1:0]    r_cnt, w_cnt_n;
    logic [WIDTH-1:0] r_hold, w_hold_n;
    logic             r_hold_full, w_hold_full_n;
    logic             r_bit_out, r_bit_valid, r_word_done;
    logic             w_bit_n, w_valid_n, w_done_n;
    logic             w_accept, w_direct, w_load, w_frame_end;
    logic [WIDTH-1:0] w_load_data;
`ifdef SER_PARITY_EN
    logic             r_par, w_par_n;
`endif

    always_comb begin
        w_accept      = i_in_valid && !r_hold_full;
        w_state_n     = r_state;
        w_shreg_n     = r_shreg;
        w_cnt_n       = r_cnt;
        w_hold_n      = r_hold;
        w_hold_full_n = r_hold_full;
        w_load        = 1'b0;
        w_load_data   = i_in_data;
        w_direct      = 1'b0;
        w_frame_end   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_load    = 1'b1;
                    w_direct  = 1'b1;
                    w_state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shreg_n = r_shreg << 1;
                w_cnt_n   = r_cnt + 1'b1;
                if (r_cnt == LAST) begin
`ifdef SER_PARITY_EN
                    w_state_n = S_PARITY;
`else
                    w_frame_end = 1'b1;
`endif
                end
            end
`ifdef SER_PARITY_EN
            S_PARITY: w_frame_end = 1'b1;
`endif
            default: w_state_n = S_IDLE;
        endcase

        // Frame boundary: a held word always drains before any new arrival.
        if (w_frame_end) begin
            if (r_hold_full) begin
                w_load        = 1'b1;
                w_load_data   = r_hold;
                w_hold_full_n = 1'b0;
                w_state_n     = S_SHIFT;
            end else if (w_accept) begin
                w_load    = 1'b1;
                w_direct  = 1'b1;
                w_state_n = S_SHIFT;
            end else begin
                w_state_n = S_IDLE;
            end
        end

        if (w_accept && !w_direct) begin
            w_hold_n      = i_in_data;
            w_hold_full_n = 1'b1;
        end

        if (w_load) begin
            w_shreg_n = w_load_data;
            w_cnt_n   = '0;
        end

`ifdef SER_PARITY_EN
        w_par_n = r_par;
        if (w_load) w_par_n = ^w_load_data;
`endif

        // Outputs are registered from next-state values so they appear with the state.
        w_bit_n   = IDLE_LEVEL;
        w_valid_n = 1'b0;
        w_done_n  = 1'b0;
        case (w_state_n)
            S_SHIFT: begin
                w_bit_n   = w_shreg_n[WIDTH-1];
                w_valid_n = 1'b1;
`ifndef SER_PARITY_EN
                w_done_n  = (w_cnt_n == LAST);
`endif
            end
`ifdef SER_PARITY_EN
            S_PARITY: begin
                w_bit_n   = w_par_n;
                w_valid_n = 1'b1;
                w_done_n  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_bit_out   <= IDLE_LEVEL;
            r_bit_valid <= 1'b0;
            r_word_done <= 1'b0;
`ifdef SER_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_n;
            r_shreg     <= w_shreg_n;
            r_cnt       <= w_cnt_n;
            r_hold      <= w_hold_n;
            r_hold_full <= w_hold_full_n;
            r_bit_out   <= w_bit_n;
            r_bit_valid <= w_valid_n;
            r_word_done <= w_done_n;
`ifdef SER_PARITY_EN
            r_par       <= w_par_n;
`endif
        end
    end

    assign o_in_ready  = !r_hold_full;
    assign o_bit_out   = r_bit_out;
    assign o_bit_valid = r_bit_valid;
    assign o_word_done = r_word_done;
    assign o_busy      = (r_state != S_IDLE) || r_hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: expected bit stream queued per accepted word and
// popped whenever the DUT flags a valid bit.
module tb_bit_serializer;

    localparam int   WIDTH      = 8;
    localparam logic IDLE_LEVEL = 1'b0;
`ifdef SER_PARITY_EN
    localparam bit   PAR = 1'b1;
`else
    localparam bit   PAR = 1'b0;
`endif
    localparam int   FR = WIDTH + (PAR ? 1 : 0);

    typedef struct packed {
        logic b;
        logic d;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] i_in_data;
    logic             i_in_valid;
    logic             o_in_ready, o_bit_out, o_bit_valid, o_word_done, o_busy;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    bit_serializer #(.WIDTH(WIDTH), .IDLE_LEVEL(IDLE_LEVEL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_data   (i_in_data),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .o_bit_out   (o_bit_out),
        .o_bit_valid (o_bit_valid),
        .o_word_done (o_word_done),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d);
        for (int i = WIDTH - 1; i >= 0; i--) sb.push_back('{b: d[i], d: (i == 0) && !PAR});
        if (PAR) sb.push_back('{b: ^d, d: 1'b1});
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d);
        i_in_valid = v;
        i_in_data  = d;
    endtask

    // Advance to the next falling edge and check that cycle's serial output.
    task automatic cyc(input logic ev);
        exp_t e;
        @(negedge clk);
        chk("bit_valid", o_bit_valid, ev);
        if (ev) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL sb_underflow: observed valid bit expected none at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("bit_out", o_bit_out, e.b);
                chk("word_done", o_word_done, e.d);
            end
        end else begin
            chk("idle_bit", o_bit_out, IDLE_LEVEL);
            chk("idle_done", o_word_done, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0);
        #2;
        chk("rst_bit_out", o_bit_out, 1'b0);
        chk("rst_bit_valid", o_bit_valid, 1'b0);
        chk("rst_word_done", o_word_done, 1'b0);
        chk("rst_in_ready", o_in_ready, 1'b1);
        chk("rst_busy", o_busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0);

        // Single word
        drive(1'b1, 8'h90);
        push_word(8'h90);
        cyc(1'b1);
        drive(1'b0, '0);
        chk("single_busy", o_busy, 1'b1);
        chk("single_ready", o_in_ready, 1'b1);
        for (int c = 2; c <= FR; c++) cyc(1'b1);
        cyc(1'b0);
        chk("single_idle_busy", o_busy, 1'b0);
        chk("single_sb_empty", sb.size() == 0, 1'b1);

        // Back-to-back through the holding register
        drive(1'b1, 8'hA5);
        push_word(8'hA5);
        cyc(1'b1);
        drive(1'b1, 8'h3C);
        push_word(8'h3C);
        cyc(1'b1);
        drive(1'b0, '0);
        chk("b2b_ready_low", o_in_ready, 1'b0);
        chk("b2b_busy", o_busy, 1'b1);
        for (int c = 3; c <= 2 * FR; c++) begin
            cyc(1'b1);
            chk("b2b_ready", o_in_ready, c > FR);
        end
        cyc(1'b0);
        chk("b2b_sb_empty", sb.size() == 0, 1'b1);

        // Second word arrives exactly on the last-bit edge
        drive(1'b1, 8'hC3);
        push_word(8'hC3);
        cyc(1'b1);
        drive(1'b0, '0);
        for (int c = 2; c <= FR; c++) cyc(1'b1);
        drive(1'b1, 8'h5A);
        push_word(8'h5A);
        cyc(1'b1);
        drive(1'b0, '0);
        chk("late0_ready", o_in_ready, 1'b1);
        for (int c = 2; c <= FR; c++) cyc(1'b1);
        cyc(1'b0);

        // Second word one cycle late: exactly one idle cycle
        drive(1'b1, 8'h0F);
        push_word(8'h0F);
        cyc(1'b1);
        drive(1'b0, '0);
        for (int c = 2; c <= FR; c++) cyc(1'b1);
        cyc(1'b0);
        drive(1'b1, 8'hE1);
        push_word(8'hE1);
        cyc(1'b1);
        drive(1'b0, '0);
        for (int c = 2; c <= FR; c++) cyc(1'b1);
        cyc(1'b0);
        chk("late1_sb_empty", sb.size() == 0, 1'b1);

        // Parity-sensitive words (odd and even bit counts)
        drive(1'b1, 8'h07);
        push_word(8'h07);
        cyc(1'b1);
        drive(1'b1, 8'h03);
        push_word(8'h03);
        cyc(1'b1);
        drive(1'b0, '0);
        for (int c = 3; c <= 2 * FR; c++) cyc(1'b1);
        cyc(1'b0);
        chk("par_sb_empty", sb.size() == 0, 1'b1);

        // Reset during bit 3 with a word waiting in hold
        drive(1'b1, 8'hFF);
        push_word(8'hFF);
        cyc(1'b1);
        drive(1'b1, 8'h81);
        cyc(1'b1);
        drive(1'b0, '0);
        chk("mid_hold_full", o_in_ready, 1'b0);
        cyc(1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bit_out", o_bit_out, 1'b0);
        chk("mid_rst_valid", o_bit_valid, 1'b0);
        chk("mid_rst_ready", o_in_ready, 1'b1);
        chk("mid_rst_busy", o_busy, 1'b0);
        sb.delete();
        cyc(1'b0);
        rst_n = 1'b1;
        for (int c = 0; c < FR + 3; c++) begin
            cyc(1'b0);
            chk("post_rst_ready", o_in_ready, 1'b1);
            chk("post_rst_busy", o_busy, 1'b0);
        end

        // Recovery after reset
        drive(1'b1, 8'h6B);
        push_word(8'h6B);
        cyc(1'b1);
        drive(1'b0, '0);
        for (int c = 2; c <= FR; c++) cyc(1'b1);
        cyc(1'b0);
        chk("final_sb_empty", sb.size() == 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
